// File: rtl/core_hs_pkg.sv
// Shared types for the multi-cycle core: FSM states, instruction classes, ALU op codes,
// device selects and the instruction field slicers.
package core_hs_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_EXECUTE = 3'd1,
    ST_MEM     = 3'd2,
    ST_PCINC   = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    INS_NOP          = 3'd0,
    INS_CALC_CONST_A = 3'd1,
    INS_CALC_CONST_B = 3'd2,
    INS_CALC         = 3'd3,
    INS_MEM_ACT      = 3'd4,
    INS_HLT          = 3'd5,
    INS_BRANCH       = 3'd6,
    INS_ILLEGAL      = 3'd7
  } ins_t;

  localparam logic [1:0] SEL_RAM  = 2'd0;
  localparam logic [1:0] SEL_UART = 2'd1;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_SLL    = 4'h5;
  localparam logic [3:0] ALU_SRL    = 4'h6;
  localparam logic [3:0] ALU_SLT    = 4'h7;
  localparam logic [3:0] ALU_PASS_B = 4'h8;
  localparam logic [3:0] ALU_PC_ADD = 4'h9;

  function automatic ins_t f_ins_t(input logic [31:0] w);
    return ins_t'(w[2:0]);
  endfunction

  function automatic logic [3:0] f_alu_op(input logic [31:0] w);
    return w[6:3];
  endfunction

  function automatic logic [4:0] f_reg_a(input logic [31:0] w);
    return w[11:7];
  endfunction

  function automatic logic [4:0] f_reg_b(input logic [31:0] w);
    return w[16:12];
  endfunction

  function automatic logic [4:0] f_reg_c(input logic [31:0] w);
    return w[21:17];
  endfunction

  function automatic logic [14:0] f_imm15(input logic [31:0] w);
    return w[31:17];
  endfunction

  function automatic logic [19:0] f_imm20(input logic [31:0] w);
    return w[31:12];
  endfunction

endpackage

// File: rtl/core_hs_if.sv
// Ready/valid memory bus between the core (master) and the device mux (slave).
interface core_hs_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 13,
  parameter int SEL_W  = 2
);
  logic              req;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic              ready;

  modport master (output req, we, sel, op, addr, wdata, input rdata, ready);
  modport slave  (input req, we, sel, op, addr, wdata, output rdata, ready);
endinterface

// File: rtl/core_hs_alu.sv
// Shared combinational ALU; the PC input lets PC-relative ops be formed without a second adder.
module core_hs_alu
  import core_hs_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic [3:0]           op,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic [BIT_WIDTH-1:0] pc,
  output logic [BIT_WIDTH-1:0] r
);
  localparam int SH_W = $clog2(BIT_WIDTH);

  always_comb begin
    r = '0;
    case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_AND:    r = a & b;
      ALU_OR:     r = a | b;
      ALU_XOR:    r = a ^ b;
      ALU_SLL:    r = a << b[SH_W-1:0];
      ALU_SRL:    r = a >> b[SH_W-1:0];
      ALU_SLT:    r = {{(BIT_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_PASS_B: r = b;
      ALU_PC_ADD: r = pc + a;
      default:    r = '0;
    endcase
  end
endmodule

// File: rtl/core_hs.sv
// Multi-cycle core with a wait-state tolerant bus; RF[31] doubles as the PC.
//   state   | meaning
//   FETCH   | issue instruction read at PC, latch INSTR on ready
//   EXECUTE | ALU writeback, branch resolve, dispatch to MEM/HALT/PCINC
//   MEM     | issue device read/write, writeback read data on ready
//   PCINC   | PC <= PC + 1
//   HALT    | terminal until reset
module core_hs
  import core_hs_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              ADDR_W    = 13,
  parameter int              NDEV      = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  core_hs_if.master  mem,
  output logic       halted,
  output logic       illegal
);
  localparam int SEL_W = (NDEV > 1) ? $clog2(NDEV) : 1;

  state_t          state;
  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] instr;
  logic [31:0]     iw;
  ins_t            ins_type;
  logic [3:0]      alu_op;
  logic [4:0]      reg_a, reg_b, reg_c;
  logic [14:0]     imm15;
  logic [XLEN-1:0] pc, alu_a, alu_b, alu_r, branch_off;
  logic            br_taken, mem_dev_ok, mem_wr;
  logic [1:0]      mem_sel_raw;

  assign iw       = instr[31:0];
  assign ins_type = f_ins_t(iw);
  assign alu_op   = f_alu_op(iw);
  assign reg_a    = f_reg_a(iw);
  assign reg_b    = f_reg_b(iw);
  assign reg_c    = f_reg_c(iw);
  assign imm15    = f_imm15(iw);
  assign pc       = rf[31];

  assign alu_a = (ins_type == INS_CALC_CONST_A) ? XLEN'(f_imm20(iw)) : rf[reg_b];
  assign alu_b = (ins_type == INS_CALC_CONST_B) ? XLEN'(imm15) : rf[reg_c];

  assign branch_off = {{(XLEN-15){imm15[14]}}, imm15};
  assign br_taken   = alu_op[0] ? (rf[reg_a] != '0) : (rf[reg_a] == '0);

  // Device select lives in the top two ALU_OP bits, the device op in the bottom two.
  assign mem_sel_raw = alu_op[3:2];
  assign mem_dev_ok  = int'(mem_sel_raw) < NDEV;
  assign mem_wr      = (alu_op[1:0] != 2'd0) && (mem_sel_raw == SEL_RAM);

  core_hs_alu #(.BIT_WIDTH(XLEN)) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .pc (pc),
    .r  (alu_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      instr <= '0;
      for (int i = 0; i < 31; i++) rf[i] <= '0;
      rf[31]    <= RESET_VEC;
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.sel   <= '0;
      mem.op    <= 2'd0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (!mem.req) begin
            mem.req  <= 1'b1;
            mem.we   <= 1'b0;
            mem.sel  <= '0;
            mem.op   <= 2'd0;
            mem.addr <= pc[ADDR_W-1:0];
          end else if (mem.ready) begin
            mem.req <= 1'b0;
            instr   <= mem.rdata;
            state   <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          case (ins_type)
            INS_CALC_CONST_A, INS_CALC_CONST_B, INS_CALC: begin
              rf[reg_a] <= alu_r;
              state     <= (reg_a == 5'd31) ? ST_FETCH : ST_PCINC;
            end
            INS_MEM_ACT: state <= ST_MEM;
            INS_HLT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            INS_BRANCH: begin
              if (br_taken) begin
                rf[31] <= pc + branch_off;
                state  <= ST_FETCH;
              end else begin
                state <= ST_PCINC;
              end
            end
            INS_ILLEGAL: begin
              illegal <= 1'b1;
              state   <= ST_PCINC;
            end
            default: state <= ST_PCINC;
          endcase
        end
        ST_MEM: begin
          if (!mem_dev_ok) begin
            // Absent device: no bus cycle, reads yield zero.
            if (!mem_wr) rf[reg_a] <= '0;
            state <= ST_PCINC;
          end else if (!mem.req) begin
            mem.req   <= 1'b1;
            mem.we    <= mem_wr;
            mem.sel   <= SEL_W'(mem_sel_raw);
            mem.op    <= alu_op[1:0];
            mem.addr  <= rf[reg_b][ADDR_W-1:0];
            mem.wdata <= rf[reg_a];
          end else if (mem.ready) begin
            mem.req <= 1'b0;
            mem.we  <= 1'b0;
            if (!mem_wr) rf[reg_a] <= mem.rdata;
            state <= (reg_a == 5'd31 && !mem_wr) ? ST_FETCH : ST_PCINC;
          end
        end
        ST_PCINC: begin
          rf[31] <= pc + XLEN'(1);
          state  <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_core_hs.sv
// Directed bench for core_hs: serves each bus transaction in program order and checks
// addresses, controls and write data against hand-computed values.
module tb_core_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted, illegal;
  int   vectors = 0;
  int   errs = 0;
  int   ill_cnt = 0;

  core_hs_if #(.XLEN(32), .ADDR_W(13), .SEL_W(2)) bus ();

  core_hs #(.XLEN(32), .ADDR_W(13), .NDEV(4), .RESET_VEC(32'd0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem     (bus),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (illegal === 1'b1) ill_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for a request, checks it, holds off `waits` cycles, then completes it.
  task automatic serve(input string tag, input logic [12:0] e_addr, input logic [1:0] e_sel,
                       input logic e_we, input logic [1:0] e_op, input logic [31:0] e_wdata,
                       input logic [31:0] rdata, input int waits);
    int n = 0;
    @(negedge clk);
    while (bus.req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 64'(bus.req), 64'(1'b1));
    if (bus.req !== 1'b1) return;
    check({tag, "_addr"}, 64'(bus.addr), 64'(e_addr));
    check({tag, "_sel"}, 64'(bus.sel), 64'(e_sel));
    check({tag, "_we"}, 64'(bus.we), 64'(e_we));
    check({tag, "_op"}, 64'(bus.op), 64'(e_op));
    if (e_we) check({tag, "_wdata"}, 64'(bus.wdata), 64'(e_wdata));
    for (int i = 0; i < waits; i++) begin
      bus.ready = 1'b0;
      @(negedge clk);
      check({tag, "_hold_req"}, 64'(bus.req), 64'(1'b1));
      check({tag, "_hold_addr"}, 64'(bus.addr), 64'(e_addr));
      check({tag, "_hold_sel"}, 64'(bus.sel), 64'(e_sel));
    end
    bus.ready = 1'b1;
    bus.rdata = rdata;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.rdata = '0;
    check({tag, "_drop"}, 64'(bus.req), 64'(1'b0));
  endtask

  task automatic fetch(input string tag, input logic [12:0] e_addr, input logic [31:0] ins, input int waits);
    serve(tag, e_addr, 2'd0, 1'b0, 2'd0, 32'd0, ins, waits);
  endtask

  function automatic logic [31:0] i_const_a(input logic [19:0] imm, input logic [4:0] ra);
    return {imm, ra, 4'h0, 3'd1};
  endfunction

  function automatic logic [31:0] i_mem(input logic [1:0] sel, input logic [1:0] op,
                                        input logic [4:0] ra, input logic [4:0] rb);
    return {10'd0, 5'd0, rb, ra, sel, op, 3'd4};
  endfunction

  function automatic logic [31:0] i_branch(input logic ne, input logic [4:0] ra, input logic [14:0] imm);
    return {imm, 5'd0, ra, 3'b000, ne, 3'd6};
  endfunction

  initial begin
    int req_hits;
    bus.ready = 1'b0;
    bus.rdata = '0;

    repeat (3) @(negedge clk);
    check("rst_req", 64'(bus.req), 64'(0));
    check("rst_we", 64'(bus.we), 64'(0));
    check("rst_sel", 64'(bus.sel), 64'(0));
    check("rst_op", 64'(bus.op), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_illegal", 64'(illegal), 64'(0));

    // Reset while a fetch request is outstanding.
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_midrst_req", 64'(bus.req), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_req_drop", 64'(bus.req), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    fetch("f0", 13'd0, i_const_a(20'd5, 5'd1), 0);
    fetch("f1", 13'd1, i_mem(2'd0, 2'd1, 5'd1, 5'd0), 0);
    serve("wr_r1", 13'd0, 2'd0, 1'b1, 2'd1, 32'd5, 32'd0, 0);
    fetch("f2", 13'd2, i_mem(2'd1, 2'd0, 5'd2, 5'd1), 1);
    serve("rd_uart", 13'd5, 2'd1, 1'b0, 2'd0, 32'd0, 32'h1234_5678, 3);
    fetch("f3", 13'd3, i_mem(2'd0, 2'd1, 5'd2, 5'd0), 0);
    serve("wr_r2", 13'd0, 2'd0, 1'b1, 2'd1, 32'h1234_5678, 32'd0, 0);
    fetch("f4", 13'd4, i_const_a(20'hDEAD, 5'd3), 0);
    fetch("f5", 13'd5, i_const_a(20'h10, 5'd4), 0);
    fetch("f6", 13'd6, i_mem(2'd0, 2'd1, 5'd3, 5'd4), 0);
    serve("wr_r3", 13'h10, 2'd0, 1'b1, 2'd1, 32'hDEAD, 32'd0, 0);
    fetch("f7", 13'd7, i_branch(1'b1, 5'd5, 15'h7FFE), 0);
    fetch("f8", 13'd8, i_const_a(20'd1, 5'd5), 0);
    fetch("f9", 13'd9, i_branch(1'b1, 5'd5, 15'h7FFE), 0);
    fetch("f7b", 13'd7, i_const_a(20'd20, 5'd31), 0);
    fetch("f20", 13'd20, i_branch(1'b0, 5'd0, 15'd3), 0);
    fetch("f23", 13'd23, {10'd0, 5'd4, 5'd3, 5'd6, 4'h1, 3'd3}, 0);
    fetch("f24", 13'd24, i_mem(2'd0, 2'd1, 5'd6, 5'd0), 0);
    serve("wr_r6", 13'd0, 2'd0, 1'b1, 2'd1, 32'hDE9D, 32'd0, 0);
    fetch("f25", 13'd25, {15'd100, 5'd1, 5'd7, 4'h0, 3'd2}, 0);
    fetch("f26", 13'd26, i_mem(2'd0, 2'd1, 5'd7, 5'd0), 0);
    serve("wr_r7", 13'd0, 2'd0, 1'b1, 2'd1, 32'd105, 32'd0, 0);
    check("illegal_none_yet", 64'(ill_cnt), 64'(0));
    fetch("f27", 13'd27, 32'h0000_0007, 0);
    fetch("f28", 13'd28, i_mem(2'd0, 2'd0, 5'd31, 5'd4), 0);
    check("illegal_pulse_cnt", 64'(ill_cnt), 64'(1));
    serve("rd_jump", 13'h10, 2'd0, 1'b0, 2'd0, 32'd0, 32'd40, 2);
    fetch("f40", 13'd40, 32'h0000_0005, 0);

    repeat (2) @(negedge clk);
    check("halted_set", 64'(halted), 64'(1));
    req_hits = 0;
    bus.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req !== 1'b0) req_hits++;
    end
    bus.ready = 1'b0;
    check("halt_req_quiet", 64'(req_hits), 64'(0));
    check("halted_hold", 64'(halted), 64'(1));
    check("illegal_total", 64'(ill_cnt), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
